// File: rtl/lr_car_detector_pkg.sv
// Shared definitions for the local-road car detector: light codes (common with the
// traffic light controller) and the waiting-car count update operation.
package lr_car_detector_pkg;

    localparam logic [2:0] LIGHT_GREEN  = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b001;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC
    } cnt_op_e;

    // Any code other than green or yellow is treated as red, so no departure counts.
    function automatic logic departure_allowed(input logic [2:0] light);
        return (light == LIGHT_GREEN) || (light == LIGHT_YELLOW);
    endfunction

    function automatic cnt_op_e count_op(input logic arr_rise, input logic dep_counted);
        if (arr_rise && !dep_counted) return CNT_INC;
        if (!arr_rise && dep_counted) return CNT_DEC;
        return CNT_HOLD;
    endfunction

endpackage

// File: rtl/lr_sensor_debounce.sv
// One loop sensor: two-flop synchroniser, mismatch-count debouncer and a registered
// single-cycle pulse on each debounced 0->1 transition.
module lr_sensor_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYC);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] mis_cnt;

    // NOTE: non-blocking assignments throughout so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb     <= 1'b0;
            rise    <= 1'b0;
            mis_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 != deb) begin
                if (mis_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    deb     <= sync2;
                    rise    <= sync2;
                    mis_cnt <= '0;
                end else begin
                    mis_cnt <= mis_cnt + CW'(1);
                end
            end else begin
                mis_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/lr_car_detector.sv
// Local-road car detector: debounced arrival/exit loops drive a saturating waiting-car
// count. Optional arrival stuck-sensor detection is enabled by macro LR_STUCK_DETECT_EN.
module lr_car_detector
    import lr_car_detector_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int MAX_CARS     = 15,
    parameter int CNT_W        = 4
`ifdef LR_STUCK_DETECT_EN
    ,
    parameter int STUCK_CYC    = 1000
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arr_raw,
    input  logic             dep_raw,
    input  logic [2:0]       lr_light,
    output logic             lr_has_car,
    output logic [CNT_W-1:0] car_cnt,
    output logic             sensor_flt
);

    logic    deb_arr;
    logic    deb_dep;
    logic    arr_rise;
    logic    dep_rise;
    logic    unused_deb;
    cnt_op_e cnt_op;

    lr_sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_arr_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (arr_raw),
        .deb  (deb_arr),
        .rise (arr_rise)
    );

    lr_sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dep_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (dep_raw),
        .deb  (deb_dep),
        .rise (dep_rise)
    );

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        cnt_op = CNT_HOLD;
        cnt_op = count_op(arr_rise, dep_rise && departure_allowed(lr_light));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_cnt <= '0;
        end else begin
            case (cnt_op)
                CNT_INC: if (car_cnt != CNT_W'(MAX_CARS)) car_cnt <= car_cnt + CNT_W'(1);
                CNT_DEC: if (car_cnt != '0)               car_cnt <= car_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

`ifdef LR_STUCK_DETECT_EN
    localparam int SW = $clog2(STUCK_CYC + 1);

    logic [SW-1:0] stuck_cnt;

    // Fault latches until reset; the counter parks at STUCK_CYC while the loop stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_cnt  <= '0;
            sensor_flt <= 1'b0;
        end else if (!deb_arr) begin
            stuck_cnt <= '0;
        end else if (stuck_cnt != SW'(STUCK_CYC)) begin
            stuck_cnt <= stuck_cnt + SW'(1);
            if (stuck_cnt == SW'(STUCK_CYC - 1)) sensor_flt <= 1'b1;
        end
    end

    // Fail-safe: a stuck arrival loop keeps the local road in the service rotation.
    assign lr_has_car = (car_cnt != '0) || sensor_flt;
    assign unused_deb = deb_dep;
`else
    assign sensor_flt = 1'b0;
    assign lr_has_car = (car_cnt != '0);
    assign unused_deb = deb_arr ^ deb_dep;
`endif

endmodule
